// File: rtl/clock_display_if.sv
// clock_display_if: time inputs and multiplexed 7-segment outputs of the display driver
interface clock_display_if;
  logic [4:0] hours;
  logic [7:0] minutes;
  logic [7:0] seconds;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       frame;
  modport master (output hours, minutes, seconds, input seg, dp, an, frame);
  modport slave  (input hours, minutes, seconds, output seg, dp, an, frame);
endinterface

// File: rtl/clock_display.sv
// clock_display: snapshots HH.MM.SS once per frame and scans it onto a six-digit 7-segment display
module clock_display #(
  parameter int SCAN_DIV = 50000
) (
  input logic           CLK50M,
  input logic           RST_N,
  clock_display_if.slave bus
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [6:0] SEG_LUT [12] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                          7'h02, 7'h78, 7'h00, 7'h10, 7'h3F, 7'h7F};
  typedef enum logic {S_HOLD, S_DRIVE} state_t;
  state_t     st_q, st_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [2:0] idx_q, idx_d;
  logic [4:0] snap_h_q, snap_h_d;
  logic [7:0] snap_m_q, snap_m_d, snap_s_q, snap_s_d;
  logic [5:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d, frame_q, frame_d;
  logic       tick, wrap, dok;
  logic [3:0] h_t, h_o, m_t, m_o, s_t, s_o, dsel, code;
  assign tick = pcnt_q == PW'(SCAN_DIV - 1);
  assign wrap = tick && idx_q == 3'd5;
  assign h_t = 4'(snap_h_q / 5'd10);
  assign h_o = 4'(snap_h_q % 5'd10);
  assign m_t = 4'(snap_m_q / 8'd10);
  assign m_o = 4'(snap_m_q % 8'd10);
  assign s_t = 4'(snap_s_q / 8'd10);
  assign s_o = 4'(snap_s_q % 8'd10);
  // Pick the BCD digit for the current slot; 10 encodes a dash, 11 a blank
  always_comb begin
    dok  = idx_q >= 3'd4 ? snap_h_q <= 5'd23 : idx_q >= 3'd2 ? snap_m_q <= 8'd59 : snap_s_q <= 8'd59;
    dsel = idx_q == 3'd5 ? h_t : idx_q == 3'd4 ? h_o : idx_q == 3'd3 ? m_t :
           idx_q == 3'd2 ? m_o : idx_q == 3'd1 ? s_t : s_o;
    code = !dok ? 4'd10 : (idx_q == 3'd5 && h_t == 4'd0) ? 4'd11 : dsel;
  end
  // Next state: prescaler, digit index, snapshot and the blank/drive output phases
  always_comb begin
    st_d     = S_HOLD;
    pcnt_d   = tick ? '0 : pcnt_q + PW'(1);
    idx_d    = tick ? (idx_q == 3'd5 ? 3'd0 : idx_q + 3'd1) : idx_q;
    snap_h_d = wrap ? bus.hours   : snap_h_q;
    snap_m_d = wrap ? bus.minutes : snap_m_q;
    snap_s_d = wrap ? bus.seconds : snap_s_q;
    frame_d  = wrap;
    an_d     = an_q;
    seg_d    = seg_q;
    dp_d     = dp_q;
    if (tick) begin
      st_d  = S_DRIVE;
      an_d  = 6'h3F;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end else if (st_q == S_DRIVE) begin
      an_d  = ~(6'd1 << idx_q);
      seg_d = SEG_LUT[code];
      dp_d  = !((idx_q == 3'd2 || idx_q == 3'd4) && !snap_s_q[0]);
    end
  end
  // State registers with asynchronous active-low reset
  always_ff @(posedge CLK50M or negedge RST_N) begin
    if (!RST_N) begin
      st_q     <= S_HOLD;
      pcnt_q   <= '0;
      idx_q    <= 3'd5;
      snap_h_q <= '0;
      snap_m_q <= '0;
      snap_s_q <= '0;
      an_q     <= 6'h3F;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      frame_q  <= 1'b0;
    end else begin
      st_q     <= st_d;
      pcnt_q   <= pcnt_d;
      idx_q    <= idx_d;
      snap_h_q <= snap_h_d;
      snap_m_q <= snap_m_d;
      snap_s_q <= snap_s_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      frame_q  <= frame_d;
    end
  end
  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.dp    = dp_q;
  assign bus.frame = frame_q;
endmodule
